// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state codes, parity encoding and the
// supported oversampling ratios.
package uart_pkg;

  // Receive FSM states
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // PAR_TYP value selecting even parity; matches the TX parity calculator
  localparam logic EVEN_PARITY = 1'b1;

  localparam int unsigned PRESCALE_8  = 8;
  localparam int unsigned PRESCALE_16 = 16;
  localparam int unsigned PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling: edge counter, three mid-bit samples, 2-of-3 vote and
// the end-of-bit strobe.
module uart_rx_sampler #(
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      active,
  input  logic                      rx_in,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done,
  output logic                      bit_val
);

  localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [2:0]                samp_q, samp_d;
  logic [PRESCALE_WIDTH-1:0] last_edge;
  logic [PRESCALE_WIDTH-1:0] first_samp;

  always_comb begin
    last_edge  = prescale - ONE;
    first_samp = (prescale >> 1) - ONE;
    bit_done   = active && (edge_cnt_q == last_edge);
    bit_val    = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                 (samp_q[1] & samp_q[2]);

    // The start-detect cycle is edge 0, so the counter resumes at 1
    edge_cnt_d = '0;
    if (start) begin
      edge_cnt_d = ONE;
    end else if (active && !bit_done) begin
      edge_cnt_d = edge_cnt_q + ONE;
    end

    samp_d = samp_q;
    if (active) begin
      for (int i = 0; i < 3; i++) begin
        if (edge_cnt_q == first_samp + PRESCALE_WIDTH'(i)) begin
          samp_d[i] = rx_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      edge_cnt_q <= '0;
      samp_q     <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      samp_q     <= samp_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deserializer: start qualification, LSB-first data shift,
// optional parity check and stop check with one-cycle result pulses.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      Data_Valid,
  output logic                      par_err,
  output logic                      stp_err
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  logic [2:0]                state_q, state_d;
  logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      par_fail_q, par_fail_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      dv_q, dv_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;

  logic start_det;
  logic active;
  logic bit_done;
  logic bit_val;
  logic exp_par;

  assign start_det = (state_q == IDLE) && !RX_IN;
  assign active    = (state_q != IDLE);
  assign exp_par   = (par_typ_q == EVEN_PARITY) ? ^shift_q : ~^shift_q;

  uart_rx_sampler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_sampler (
    .clk     (CLK),
    .rst     (RST),
    .start   (start_det),
    .active  (active),
    .rx_in   (RX_IN),
    .prescale(presc_q),
    .bit_done(bit_done),
    .bit_val (bit_val)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    p_data_d   = p_data_q;
    dv_d       = 1'b0;
    par_err_d  = 1'b0;
    stp_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Frame settings are frozen here so mid-frame changes cannot corrupt timing
        if (!RX_IN) begin
          state_d   = START;
          presc_d   = Prescale;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
        end
      end
      START: begin
        if (bit_done) begin
          if (bit_val) begin
            state_d = IDLE;
          end else begin
            state_d    = DATA;
            bit_cnt_d  = '0;
            par_fail_d = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d[bit_cnt_q] = bit_val;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          par_fail_d = (bit_val != exp_par);
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d   = IDLE;
          stp_err_d = !bit_val;
          par_err_d = par_fail_q;
          if (bit_val && !par_fail_q) begin
            dv_d     = 1'b1;
            p_data_d = shift_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      p_data_q   <= '0;
      dv_q       <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      p_data_q   <= p_data_d;
      dv_q       <= dv_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign Data_Valid = dv_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: serial frames driven bit by bit, result
// pulses collected on the falling edge and checked with immediate assertions.
module tb_uart_rx_frame;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] Prescale = 6'd8;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       par_err;
  logic       stp_err;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_cyc;
  int dv_cnt, pe_cnt, se_cnt;
  int dv_times[$];
  int dv_vals[$];

  uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .par_err   (par_err),
    .stp_err   (stp_err)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (Data_Valid) begin
      dv_cnt++;
      dv_times.push_back(cyc);
      dv_vals.push_back(int'(P_DATA));
    end
    if (par_err) pe_cnt++;
    if (stp_err) se_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    dv_cnt = 0;
    pe_cnt = 0;
    se_cnt = 0;
    dv_times.delete();
    dv_vals.delete();
  endtask

  // Called on a falling edge; returns on the falling edge that ends the stop bit.
  // Frame settings are scrambled after the start bit to show they were latched.
  task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                            input logic ptyp, input logic par_bit, input logic stop_bit);
    Prescale  = 6'(p);
    PAR_EN    = pen;
    PAR_TYP   = ptyp;
    RX_IN     = 1'b0;
    start_cyc = cyc;
    repeat (p) @(negedge CLK);
    Prescale = (p == 32) ? 6'd8 : 6'd32;
    PAR_EN   = ~pen;
    PAR_TYP  = ~ptyp;
    for (int i = 0; i < 8; i++) begin
      RX_IN = data[i];
      repeat (p) @(negedge CLK);
    end
    if (pen) begin
      RX_IN = par_bit;
      repeat (p) @(negedge CLK);
    end
    RX_IN = stop_bit;
    repeat (p) @(negedge CLK);
  endtask

  initial begin
    int t0;
    clear_log();
    repeat (3) @(negedge CLK);
    chk("reset_p_data", int'(P_DATA), 0);
    chk("reset_dv", int'(Data_Valid), 0);
    chk("reset_errs", int'({par_err, stp_err}), 0);
    RST = 1'b0;
    repeat (4) @(negedge CLK);

    // Good frame with even parity, 11 bits at P=8
    clear_log();
    send_frame(8'hA5, PRESCALE_8, 1'b1, EVEN_PARITY, 1'b0, 1'b1);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t1_dv_cnt", dv_cnt, 1);
    chk("t1_latency", (dv_times.size() > 0) ? dv_times[0] - start_cyc : -1, 88);
    chk("t1_p_data", int'(P_DATA), 'hA5);
    chk("t1_errs", pe_cnt + se_cnt, 0);

    // Odd parity expected 1, sent 0
    clear_log();
    send_frame(8'h3C, PRESCALE_16, 1'b1, 1'b0, 1'b0, 1'b1);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t2_par_err", pe_cnt, 1);
    chk("t2_dv_cnt", dv_cnt, 0);
    chk("t2_stp_err", se_cnt, 0);
    chk("t2_p_data_kept", int'(P_DATA), 'hA5);

    // Stop bit low, no parity
    clear_log();
    send_frame(8'h5A, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b0);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t3_stp_err", se_cnt, 1);
    chk("t3_par_err", pe_cnt, 0);
    chk("t3_dv_cnt", dv_cnt, 0);
    chk("t3_p_data_kept", int'(P_DATA), 'hA5);
    chk("t3_state_idle", int'(dut.state_q), int'(IDLE));

    // Two-cycle glitch, then a real frame
    clear_log();
    Prescale = 6'd8;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK);
    chk("t4_glitch_pulses", dv_cnt + pe_cnt + se_cnt, 0);
    chk("t4_glitch_idle", int'(dut.state_q), int'(IDLE));
    send_frame(8'h12, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t4_dv_cnt", dv_cnt, 1);
    chk("t4_p_data", int'(P_DATA), 'h12);
    chk("t4_latency", (dv_times.size() > 0) ? dv_times[0] - start_cyc : -1, 80);

    // Back-to-back frames with no idle gap at P=32
    clear_log();
    send_frame(8'h00, PRESCALE_32, 1'b0, 1'b0, 1'b0, 1'b1);
    t0 = start_cyc;
    send_frame(8'hFF, PRESCALE_32, 1'b0, 1'b0, 1'b0, 1'b1);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t5_dv_cnt", dv_cnt, 2);
    chk("t5_first_data", (dv_vals.size() > 0) ? dv_vals[0] : -1, 'h00);
    chk("t5_second_data", (dv_vals.size() > 1) ? dv_vals[1] : -1, 'hFF);
    chk("t5_first_latency", (dv_times.size() > 0) ? dv_times[0] - t0 : -1, 320);
    chk("t5_spacing", (dv_times.size() > 1) ? dv_times[1] - dv_times[0] : -1, 320);
    chk("t5_errs", pe_cnt + se_cnt, 0);

    // Reset in the middle of bit 4 of 0x81
    clear_log();
    Prescale = 6'd8;
    PAR_EN   = 1'b0;
    RX_IN    = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      RX_IN = (i == 0) ? 1'b1 : 1'b0;
      repeat (8) @(negedge CLK);
    end
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("t6_rst_p_data", int'(P_DATA), 0);
    chk("t6_rst_outs", int'({Data_Valid, par_err, stp_err}), 0);
    RST = 1'b0;
    RX_IN = 1'b1;
    repeat (60) @(negedge CLK);
    chk("t6_no_pulse", dv_cnt + pe_cnt + se_cnt, 0);
    send_frame(8'h7E, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1);
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    chk("t6_dv_cnt", dv_cnt, 1);
    chk("t6_p_data", int'(P_DATA), 'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
